// File: rtl/bpm_estimator.sv
// Heartbeat interval averager with a rounded restoring divider producing BPM_estimate.
// Define BPM_OUTLIER_REJECT_EN to drop intervals more than 50% off the locked average.
module bpm_estimator #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned MAX_BPM   = 200,
   parameter int unsigned MIN_BPM   = 30,
   parameter int unsigned AVG_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           beat_in,
   output logic [$clog2(MAX_BPM+1)-1:0]   BPM_estimate,
   output logic                           bpm_valid,
   output logic                           locked,
   output logic                           beat_accepted
);
   localparam longint unsigned MIN_INT = 64'd60 * CLK_HZ / MAX_BPM;
   localparam longint unsigned TIMEOUT = 64'd60 * CLK_HZ / MIN_BPM;
   localparam longint unsigned NUM     = 64'd60 * CLK_HZ * AVG_DEPTH;
   localparam int CNT_W  = $clog2(TIMEOUT + 64'd1);
   localparam int LOG_D  = $clog2(AVG_DEPTH);
   localparam int SUM_W  = CNT_W + LOG_D;
   localparam int DW     = $clog2(NUM + (64'd1 << SUM_W));
   localparam int BW     = $clog2(MAX_BPM + 1);
   localparam int ACC_W  = $clog2(AVG_DEPTH + 1);
   localparam int STEP_W = $clog2(DW + 1);

   localparam logic [CNT_W-1:0]  MIN_INT_C  = CNT_W'(MIN_INT);
   localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [DW-1:0]     NUM_C      = DW'(NUM);
   localparam logic [DW-1:0]     MAX_Q_C    = DW'(MAX_BPM);
   localparam logic [BW-1:0]     MAX_BPM_C  = BW'(MAX_BPM);
   localparam logic [ACC_W-1:0]  ACC_FULL_C = ACC_W'(AVG_DEPTH);
   localparam logic [STEP_W-1:0] DW_STEPS_C = STEP_W'(DW);

   if (MIN_INT <= DW + 4) begin : g_bad_min_int
      $error("bpm_estimator: refractory interval shorter than divider latency");
   end
   if ((AVG_DEPTH < 2) || ((AVG_DEPTH & (AVG_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("bpm_estimator: AVG_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEASURE = 2'd1, S_DIVIDE = 2'd2} state_t;

   state_t             state_r, state_nxt_s;
   logic               beat_q_r, edge_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   ring_r [AVG_DEPTH];
   logic [LOG_D-1:0]   ptr_r;
   logic [SUM_W-1:0]   sum_r;
   logic               primed_r;
   logic [ACC_W-1:0]   acc_r;
   logic [STEP_W-1:0]  step_r;
   logic [DW-1:0]      dq_r;
   logic [SUM_W-1:0]   rem_r;
   logic [BW-1:0]      bpm_r;
   logic               bpm_valid_r, locked_r, beat_acc_r;
   logic               start_s, take_s, prime_s, reject_s, timeout_s, div_done_s, qbit_s;
   logic [SUM_W:0]     trial_s;
   logic [SUM_W-1:0]   rem_nxt_s;
   logic [DW-1:0]      q_final_s;

`ifdef BPM_OUTLIER_REJECT_EN
   logic               rej_pend_r, outlier_s;
   logic [SUM_W-1:0]   id_s, diff_s;

   // Distance of the candidate interval from the running average, scaled by AVG_DEPTH
   always_comb begin
      id_s = {cnt_r, {LOG_D{1'b0}}};
      if (id_s > sum_r) begin
         diff_s = id_s - sum_r;
      end else begin
         diff_s = sum_r - id_s;
      end
      outlier_s = diff_s > (sum_r >> 1);
   end

   // Remembers a pending rejection so a second consecutive outlier re-primes the average
   always_ff @(posedge clk) begin
      if (reset || timeout_s) begin
         rej_pend_r <= 1'b0;
      end else if (reject_s) begin
         rej_pend_r <= 1'b1;
      end else if (take_s) begin
         rej_pend_r <= 1'b0;
      end
   end
`endif

   // One restoring-division step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      trial_s = {rem_r, dq_r[DW-1]};
      if (trial_s >= {1'b0, sum_r}) begin
         qbit_s    = 1'b1;
         rem_nxt_s = SUM_W'(trial_s - {1'b0, sum_r});
      end else begin
         qbit_s    = 1'b0;
         rem_nxt_s = SUM_W'(trial_s);
      end
      q_final_s = {dq_r[DW-2:0], qbit_s};
   end

   // Next-state and event decode
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      take_s      = 1'b0;
      prime_s     = 1'b0;
      reject_s    = 1'b0;
      timeout_s   = 1'b0;
      div_done_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (edge_r) begin
               start_s     = 1'b1;
               state_nxt_s = S_MEASURE;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_MEASURE: begin
            // timeout wins over a coincident edge, which is then lost
            if (cnt_r == TIMEOUT_C) begin
               timeout_s   = 1'b1;
               state_nxt_s = S_IDLE;
            end else if (edge_r && (cnt_r >= MIN_INT_C)) begin
`ifdef BPM_OUTLIER_REJECT_EN
               if (locked_r && outlier_s && !rej_pend_r) begin
                  reject_s    = 1'b1;
                  state_nxt_s = S_MEASURE;
               end else begin
                  take_s      = 1'b1;
                  prime_s     = !primed_r || (locked_r && outlier_s);
                  state_nxt_s = S_DIVIDE;
               end
`else
               take_s      = 1'b1;
               prime_s     = !primed_r;
               state_nxt_s = S_DIVIDE;
`endif
            end else begin
               state_nxt_s = S_MEASURE;
            end
         end
         S_DIVIDE: begin
            if (step_r == DW_STEPS_C) begin
               div_done_s  = 1'b1;
               state_nxt_s = S_MEASURE;
            end else begin
               state_nxt_s = S_DIVIDE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Edge detect, interval counter and accept strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q_r   <= 1'b0;
         edge_r     <= 1'b0;
         cnt_r      <= '0;
         beat_acc_r <= 1'b0;
      end else begin
         beat_q_r   <= beat_in;
         edge_r     <= beat_in & ~beat_q_r;
         beat_acc_r <= start_s | take_s | reject_s;
         // the accept cycle is the first cycle of the new interval, so cnt equals the edge spacing
         if (start_s | take_s | reject_s) begin
            cnt_r <= CNT_W'(1);
         end else if (timeout_s) begin
            cnt_r <= '0;
         end else if ((state_r != S_IDLE) && (cnt_r != TIMEOUT_C)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Interval ring, running sum and accepted-interval count
   always_ff @(posedge clk) begin
      if (reset || timeout_s) begin
         for (int i = 0; i < int'(AVG_DEPTH); i++) begin
            ring_r[i] <= '0;
         end
         ptr_r    <= '0;
         sum_r    <= '0;
         primed_r <= 1'b0;
         acc_r    <= '0;
      end else if (take_s) begin
         if (prime_s) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) begin
               ring_r[i] <= cnt_r;
            end
            ptr_r    <= '0;
            sum_r    <= {cnt_r, {LOG_D{1'b0}}};
            primed_r <= 1'b1;
            acc_r    <= ACC_W'(1);
         end else begin
            ring_r[ptr_r] <= cnt_r;
            ptr_r         <= ptr_r + LOG_D'(1);
            sum_r         <= sum_r - SUM_W'(ring_r[ptr_r]) + SUM_W'(cnt_r);
            if (acc_r != ACC_FULL_C) begin
               acc_r <= acc_r + ACC_W'(1);
            end
         end
      end
   end

   // Divider sequencing and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         step_r      <= '0;
         dq_r        <= '0;
         rem_r       <= '0;
         bpm_r       <= '0;
         bpm_valid_r <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         bpm_valid_r <= timeout_s | div_done_s;
         if (timeout_s) begin
            bpm_r    <= '0;
            locked_r <= 1'b0;
         end else if (div_done_s) begin
            bpm_r    <= (q_final_s > MAX_Q_C) ? MAX_BPM_C : q_final_s[BW-1:0];
            locked_r <= (acc_r == ACC_FULL_C);
         end else if (prime_s) begin
            locked_r <= 1'b0;
         end
         if (state_r == S_DIVIDE) begin
            // step 0 loads NUM + sum/2 so the quotient rounds to nearest
            if (step_r == '0) begin
               dq_r  <= NUM_C + DW'(sum_r >> 1);
               rem_r <= '0;
            end else begin
               dq_r  <= q_final_s;
               rem_r <= rem_nxt_s;
            end
            step_r <= div_done_s ? '0 : step_r + STEP_W'(1);
         end
      end
   end

   assign BPM_estimate  = bpm_r;
   assign bpm_valid     = bpm_valid_r;
   assign locked        = locked_r;
   assign beat_accepted = beat_acc_r;

endmodule
